// File: rtl/tmds_rx_decode.sv
// TMDS receive symbol aligner and decoder.
// Hunts for the 10-bit word boundary by looking for a run of control tokens
// at each bit offset, then decodes control, guard-band, TERC4 and video
// symbols at the locked offset. All decoded outputs are registered.
//
// Build option: define TMDS_RX_TERC4_EN to include the TERC4 lookup
// (is_terc/terc); without it those outputs are tied to 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_HUNT | searching; slip one bit after HUNT_LEN cycles without a lock
// S_LOCK | aligned; drop back to S_HUNT after CTL_TIMEOUT cycles with
//        | no control token

module tmds_rx_decode #(
  parameter int CTL_RUN     = 16,
  parameter int HUNT_LEN    = 2048,
  parameter int CTL_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic [9:0] din,
  output logic       locked,
  output logic [3:0] offset,
  output logic       is_ctl,
  output logic       is_guard,
  output logic       is_terc,
  output logic [1:0] ctl,
  output logic [3:0] terc,
  output logic [7:0] vdata
);

  // One timer is shared: hunt dwell time in S_HUNT, control timeout in S_LOCK.
  localparam int TMAX = (HUNT_LEN > CTL_TIMEOUT) ? HUNT_LEN : CTL_TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW   = $clog2(CTL_RUN + 1);

  typedef enum logic {
    S_HUNT = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    offset_nxt, offset_adv;
  logic [RW-1:0] run, run_nxt;
  logic [TW-1:0] timer, timer_nxt;

  logic [9:0]  prev;
  logic [19:0] w;
  logic [9:0]  sym;

  logic        ctl_hit;
  logic [1:0]  ctl_code;
  logic        guard_hit;
  logic        terc_hit;
  logic [3:0]  terc_code;
  logic [7:0]  t_bits;
  logic [7:0]  vid;

  // Hold the previous word so a symbol spanning two words can be extracted.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) prev <= '0;
    else         prev <= din;
  end

  assign w = {din, prev};

  // Barrel select of the aligned symbol; offsets above 9 never occur.
  always_comb begin
    sym = w[9:0];
    for (int k = 1; k < 10; k++) begin
      if (offset == 4'(k)) sym = w[k +: 10];
    end
  end

  // Control token decode.
  always_comb begin
    ctl_hit  = 1'b0;
    ctl_code = 2'b00;
    case (sym)
      10'b1101010100: begin ctl_hit = 1'b1; ctl_code = 2'b00; end
      10'b0010101011: begin ctl_hit = 1'b1; ctl_code = 2'b01; end
      10'b0101010100: begin ctl_hit = 1'b1; ctl_code = 2'b10; end
      10'b1010101011: begin ctl_hit = 1'b1; ctl_code = 2'b11; end
      default:        begin ctl_hit = 1'b0; ctl_code = 2'b00; end
    endcase
  end

  assign guard_hit = (sym == 10'b1011001100) || (sym == 10'b0100110011);

`ifdef TMDS_RX_TERC4_EN
  // TERC4 lookup, identical to the transmitter's encode table read backwards.
  always_comb begin
    terc_hit  = 1'b1;
    terc_code = 4'b0000;
    case (sym)
      10'b1010011100: terc_code = 4'b0000;
      10'b1001100011: terc_code = 4'b0001;
      10'b1011100100: terc_code = 4'b0010;
      10'b1011100010: terc_code = 4'b0011;
      10'b0101110001: terc_code = 4'b0100;
      10'b0100011110: terc_code = 4'b0101;
      10'b0110001110: terc_code = 4'b0110;
      10'b0100111100: terc_code = 4'b0111;
      10'b1011001100: terc_code = 4'b1000;
      10'b0100111001: terc_code = 4'b1001;
      10'b0110011100: terc_code = 4'b1010;
      10'b1011000110: terc_code = 4'b1011;
      10'b1010001110: terc_code = 4'b1100;
      10'b1001110001: terc_code = 4'b1101;
      10'b0101100011: terc_code = 4'b1110;
      10'b1011000011: terc_code = 4'b1111;
      default:        terc_hit  = 1'b0;
    endcase
  end
`else
  assign terc_hit  = 1'b0;
  assign terc_code = 4'b0000;
`endif

  // TMDS video decode: undo optional inversion, then XOR/XNOR chain.
  always_comb begin
    t_bits = sym[9] ? ~sym[7:0] : sym[7:0];
    vid    = '0;
    vid[0] = t_bits[0];
    for (int i = 1; i < 8; i++) begin
      vid[i] = sym[8] ? (t_bits[i] ^ t_bits[i-1]) : ~(t_bits[i] ^ t_bits[i-1]);
    end
  end

  assign offset_adv = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  // Next-state logic: run counting, hunt slips and lock timeout.
  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    run_nxt    = run;
    timer_nxt  = timer;
    case (state)
      S_HUNT: begin
        if (ctl_hit && (run == RW'(CTL_RUN - 1))) begin
          // Lock takes priority over a coinciding slip.
          state_nxt = S_LOCK;
          run_nxt   = RW'(CTL_RUN);
          timer_nxt = '0;
        end else begin
          if (ctl_hit) run_nxt = run + RW'(1);
          else         run_nxt = '0;
          if (timer == TW'(HUNT_LEN - 1)) begin
            offset_nxt = offset_adv;
            run_nxt    = '0;
            timer_nxt  = '0;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
      end
      S_LOCK: begin
        if (ctl_hit) begin
          timer_nxt = '0;
        end else if (timer == TW'(CTL_TIMEOUT - 1)) begin
          state_nxt  = S_HUNT;
          offset_nxt = offset_adv;
          run_nxt    = '0;
          timer_nxt  = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        state_nxt  = S_HUNT;
        offset_nxt = 4'd0;
        run_nxt    = '0;
        timer_nxt  = '0;
      end
    endcase
  end

  // Alignment state registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state  <= S_HUNT;
      offset <= 4'd0;
      run    <= '0;
      timer  <= '0;
    end else begin
      state  <= state_nxt;
      offset <= offset_nxt;
      run    <= run_nxt;
      timer  <= timer_nxt;
    end
  end

  // Decoded outputs; gated by the next state so they line up with locked.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      is_ctl   <= 1'b0;
      is_guard <= 1'b0;
      is_terc  <= 1'b0;
      ctl      <= 2'b00;
      terc     <= 4'b0000;
      vdata    <= 8'h00;
    end else if (state_nxt == S_LOCK) begin
      is_ctl   <= ctl_hit;
      is_guard <= guard_hit;
      is_terc  <= terc_hit;
      ctl      <= ctl_code;
      terc     <= terc_code;
      vdata    <= vid;
    end else begin
      is_ctl   <= 1'b0;
      is_guard <= 1'b0;
      is_terc  <= 1'b0;
      ctl      <= 2'b00;
      terc     <= 4'b0000;
      vdata    <= 8'h00;
    end
  end

  assign locked = (state == S_LOCK);

endmodule

// File: tb/tb_tmds_rx_decode.sv
// Directed bench for tmds_rx_decode: lock, decode, guard/TERC4, timeout,
// slip/lock coincidence, offset hunting and mid-lock reset.
// Honours TMDS_RX_TERC4_EN for the TERC4 expectations.

module tb_tmds_rx_decode;

  logic       clk;
  logic       resetq;
  logic [9:0] din;
  logic       locked;
  logic [3:0] offset;
  logic       is_ctl;
  logic       is_guard;
  logic       is_terc;
  logic [1:0] ctl;
  logic [3:0] terc;
  logic [7:0] vdata;

  int checks = 0;
  int errors = 0;

`ifdef TMDS_RX_TERC4_EN
  localparam bit TERC_EN = 1'b1;
`else
  localparam bit TERC_EN = 1'b0;
`endif

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  tmds_rx_decode dut (
    .clk      (clk),
    .resetq   (resetq),
    .din      (din),
    .locked   (locked),
    .offset   (offset),
    .is_ctl   (is_ctl),
    .is_guard (is_guard),
    .is_terc  (is_terc),
    .ctl      (ctl),
    .terc     (terc),
    .vdata    (vdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and park on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Insert one symbol into a TOK0 stream; returns when its decode is visible.
  task automatic send_sym(input logic [9:0] s);
    din = s;
    tick(1);
    din = TOK0;
    tick(1);
  endtask

  task automatic test_reset;
    resetq = 1'b0;
    din    = TOK0;
    tick(2);
    checks++;
    if ({locked, offset, is_ctl, is_guard, is_terc, ctl, terc, vdata} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {locked, offset, is_ctl, is_guard, is_terc, ctl, terc, vdata});
    end
  endtask

  task automatic test_ctl_lock;
    resetq = 1'b1;
    tick(16);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: locked=%b required 0", locked);
    end
    tick(1);
    checks++;
    if ({locked, is_ctl, ctl, offset} !== {1'b1, 1'b1, 2'b00, 4'd0}) begin
      errors++;
      $display("FAIL lock_16th: locked=%b is_ctl=%b ctl=%b offset=%0d required 1 1 00 0",
               locked, is_ctl, ctl, offset);
    end
    tick(3);
    checks++;
    if ({locked, is_ctl, ctl} !== {1'b1, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL lock_hold: locked=%b is_ctl=%b ctl=%b required 1 1 00",
               locked, is_ctl, ctl);
    end
  endtask

  task automatic test_video;
    send_sym(10'b0100000000);
    checks++;
    if ({locked, is_ctl, vdata} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL video_00: locked=%b is_ctl=%b vdata=%h required 1 0 00",
               locked, is_ctl, vdata);
    end
    send_sym(10'b1011110000);
    checks++;
    if ({is_ctl, vdata} !== {1'b0, 8'hEF}) begin
      errors++;
      $display("FAIL video_ef: is_ctl=%b vdata=%h required 0 ef", is_ctl, vdata);
    end
    send_sym(10'b0100000001);
    checks++;
    if (vdata !== 8'h03) begin
      errors++;
      $display("FAIL video_03: vdata=%h required 03", vdata);
    end
    send_sym(TOK2);
    checks++;
    if ({is_ctl, ctl} !== {1'b1, 2'b10}) begin
      errors++;
      $display("FAIL ctl_10: is_ctl=%b ctl=%b required 1 10", is_ctl, ctl);
    end
    send_sym(TOK3);
    checks++;
    if ({is_ctl, ctl} !== {1'b1, 2'b11}) begin
      errors++;
      $display("FAIL ctl_11: is_ctl=%b ctl=%b required 1 11", is_ctl, ctl);
    end
    send_sym(TOK1);
    checks++;
    if ({is_ctl, ctl} !== {1'b1, 2'b01}) begin
      errors++;
      $display("FAIL ctl_01: is_ctl=%b ctl=%b required 1 01", is_ctl, ctl);
    end
  endtask

  task automatic test_guard_terc;
    send_sym(10'b1011001100);
    checks++;
    if ({is_guard, is_terc, terc, is_ctl, vdata} !==
        {1'b1, TERC_EN, (TERC_EN ? 4'b1000 : 4'b0000), 1'b0, 8'hAB}) begin
      errors++;
      $display("FAIL guard_terc8: guard=%b terc_f=%b terc=%b is_ctl=%b vdata=%h required 1 %b %b 0 ab",
               is_guard, is_terc, terc, is_ctl, vdata, TERC_EN,
               (TERC_EN ? 4'b1000 : 4'b0000));
    end
    send_sym(10'b0100110011);
    checks++;
    if ({is_guard, is_terc, terc} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL guard_alt: guard=%b terc_f=%b terc=%b required 1 0 0000",
               is_guard, is_terc, terc);
    end
    send_sym(10'b1010011100);
    checks++;
    if ({is_guard, is_terc, terc} !== {1'b0, TERC_EN, 4'b0000}) begin
      errors++;
      $display("FAIL terc_0: guard=%b terc_f=%b terc=%b required 0 %b 0000",
               is_guard, is_terc, terc, TERC_EN);
    end
    send_sym(10'b1001100011);
    checks++;
    if ({is_guard, is_terc, terc} !== {1'b0, TERC_EN, (TERC_EN ? 4'b0001 : 4'b0000)}) begin
      errors++;
      $display("FAIL terc_1: guard=%b terc_f=%b terc=%b required 0 %b %b",
               is_guard, is_terc, terc, TERC_EN, (TERC_EN ? 4'b0001 : 4'b0000));
    end
  endtask

  task automatic test_timeout;
    din = 10'b1011110000;
    tick(1);
    tick(4095);
    checks++;
    if ({locked, offset, vdata} !== {1'b1, 4'd0, 8'hEF}) begin
      errors++;
      $display("FAIL timeout_early: locked=%b offset=%0d vdata=%h required 1 0 ef",
               locked, offset, vdata);
    end
    tick(1);
    checks++;
    if ({locked, offset, vdata, is_ctl} !== {1'b0, 4'd1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL timeout_drop: locked=%b offset=%0d vdata=%h is_ctl=%b required 0 1 00 0",
               locked, offset, vdata, is_ctl);
    end
  endtask

  task automatic test_coincide;
    resetq = 1'b0;
    din    = 10'b1011110000;
    tick(1);
    resetq = 1'b1;
    tick(2031);
    din = TOK0;
    tick(16);
    checks++;
    if ({locked, offset} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL coincide_pre: locked=%b offset=%0d required 0 0", locked, offset);
    end
    tick(1);
    checks++;
    if ({locked, offset, is_ctl} !== {1'b1, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL coincide_lock: locked=%b offset=%0d is_ctl=%b required 1 0 1",
               locked, offset, is_ctl);
    end
  endtask

  task automatic test_hunt;
    resetq = 1'b0;
    din    = 10'b0101011001;
    tick(1);
    resetq = 1'b1;
    tick(2047);
    checks++;
    if (offset !== 4'd0) begin
      errors++;
      $display("FAIL hunt_off0: offset=%0d required 0", offset);
    end
    tick(1);
    checks++;
    if (offset !== 4'd1) begin
      errors++;
      $display("FAIL hunt_off1: offset=%0d required 1", offset);
    end
    tick(4095);
    checks++;
    if (offset !== 4'd2) begin
      errors++;
      $display("FAIL hunt_off2: offset=%0d required 2", offset);
    end
    tick(1);
    checks++;
    if ({offset, locked} !== {4'd3, 1'b0}) begin
      errors++;
      $display("FAIL hunt_off3: offset=%0d locked=%b required 3 0", offset, locked);
    end
    tick(15);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL hunt_lock_early: locked=%b required 0", locked);
    end
    tick(1);
    checks++;
    if ({locked, offset, is_ctl, ctl} !== {1'b1, 4'd3, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL hunt_lock: locked=%b offset=%0d is_ctl=%b ctl=%b required 1 3 1 01",
               locked, offset, is_ctl, ctl);
    end
  endtask

  task automatic test_reset_mid_lock;
    #2 resetq = 1'b0;
    #1;
    checks++;
    if ({locked, offset, is_ctl, ctl} !== {1'b0, 4'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_lock: locked=%b offset=%0d is_ctl=%b ctl=%b required 0 0 0 00",
               locked, offset, is_ctl, ctl);
    end
    tick(1);
    resetq = 1'b1;
  endtask

  initial begin
    resetq = 1'b0;
    din    = TOK0;
    test_reset();
    test_ctl_lock();
    test_video();
    test_guard_terc();
    test_timeout();
    test_coincide();
    test_hunt();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
